// File: rtl/posit_round_norm_sched.sv
// -----------------------------------------------------------------------------
// posit_round_norm_sched
//
// Shares one combinational posit round/normalize/saturate datapath between
// N_REQ producers. A round-robin arbiter picks one requester per cycle and
// loads its operation into stage 1. Stage 1 drives the external datapath
// (rn_*). Stage 2 captures the datapath result and presents it downstream
// with valid/ready back-pressure. Each operation carries a precision mode
// (full / 2x half / 4x quart) and an opaque tag.
//
// Optional feature (macro POSIT_RN_SCHED_STATS_EN):
//   Adds saturating per-requester handshake counters and an output-stall
//   cycle counter. When the macro is undefined, those ports are absent.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake (N_REQ bits each)
//   req_mode            2 bits per requester: 0 full, 1 half, 2 quart, 3 reserved
//   req_exp/mant/tag    per-requester payload bundles
//   rn_mode/exp/mant    stage-1 operands to the shared datapath
//   rn_res              datapath result, combinational from rn_*
//   out_valid/ready     result handshake
//   out_res/mode/tag    registered result and its side-band
//   out_src             index of the requester that issued the result
//   err_mode            sticky flag: a reserved mode was accepted
//   stat_grant_cnt      (stats build) 16 bits per requester, requester 0 at LSBs
//   stat_stall_cnt      (stats build) cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module posit_round_norm_sched #(
   parameter int N_REQ  = 2,
   parameter int EXP_W  = 32,
   parameter int MANT_W = 32,
   parameter int RES_W  = 56,
   parameter int TAG_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*2-1:0]         req_mode,
   input  logic [N_REQ*EXP_W-1:0]     req_exp,
   input  logic [N_REQ*MANT_W-1:0]    req_mant,
   input  logic [N_REQ*TAG_W-1:0]     req_tag,
   output logic [1:0]                 rn_mode,
   output logic [EXP_W-1:0]           rn_exp,
   output logic [MANT_W-1:0]          rn_mant,
   input  logic [RES_W-1:0]           rn_res,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [RES_W-1:0]           out_res,
   output logic [1:0]                 out_mode,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(N_REQ)-1:0]   out_src,
   output logic                       err_mode
`ifdef POSIT_RN_SCHED_STATS_EN
   ,
   output logic [N_REQ*16-1:0]        stat_grant_cnt,
   output logic [15:0]                stat_stall_cnt
`endif
);

   localparam int SRC_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      MODE_FULL  = 2'd0,
      MODE_HALF  = 2'd1,
      MODE_QUART = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   logic             s1_valid;
   logic [TAG_W-1:0] s1_tag;
   logic [SRC_W-1:0] s1_src;
   logic             s2_valid;
   logic [SRC_W-1:0] rr_ptr;

   logic             s1_adv;
   logic             s2_adv;
   logic             s1_keep;
   logic             grant_found;
   logic [SRC_W-1:0] grant_idx;
   logic             hs;
   int               idx;
   logic [SRC_W-1:0] cand;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign out_valid = s2_valid;

   // Reserved-mode operations are consumed at the s1->s2 boundary, never emitted.
   assign s1_keep   = s1_valid && (rn_mode != MODE_RSVD);

   // Round-robin: scan from the highest offset down so the requester closest
   // to rr_ptr is the last (and therefore winning) assignment.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      cand        = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = SRC_W'(idx);
         if (req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Ready is masked during reset so nothing is accepted while state clears.
   assign hs = grant_found && s1_adv && !rst;

   always_comb begin
      req_ready = '0;
      if (hs) req_ready[grant_idx] = 1'b1;
   end

   // Stage 1: arbitration winner, drives the shared datapath directly.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         s1_valid <= 1'b0;
         rn_mode  <= '0;
         rn_exp   <= '0;
         rn_mant  <= '0;
         s1_tag   <= '0;
         s1_src   <= '0;
         rr_ptr   <= '0;
         err_mode <= 1'b0;
      end else if (hs) begin
         s1_valid <= 1'b1;
         rn_mode  <= req_mode[grant_idx*2 +: 2];
         rn_exp   <= req_exp[grant_idx*EXP_W +: EXP_W];
         rn_mant  <= req_mant[grant_idx*MANT_W +: MANT_W];
         s1_tag   <= req_tag[grant_idx*TAG_W +: TAG_W];
         s1_src   <= grant_idx;
         rr_ptr   <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
         if (req_mode[grant_idx*2 +: 2] == MODE_RSVD) err_mode <= 1'b1;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: registered result; payload only changes when a kept op lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         out_res  <= '0;
         out_mode <= '0;
         out_tag  <= '0;
         out_src  <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_keep;
         if (s1_keep) begin
            out_res  <= rn_res;
            out_mode <= rn_mode;
            out_tag  <= s1_tag;
            out_src  <= s1_src;
         end
      end
   end

`ifdef POSIT_RN_SCHED_STATS_EN
   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grant_cnt <= '0;
         stat_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && stat_grant_cnt[i*16 +: 16] != 16'hFFFF)
               stat_grant_cnt[i*16 +: 16] <= stat_grant_cnt[i*16 +: 16] + 16'd1;
         end
         if (s2_valid && !out_ready && stat_stall_cnt != 16'hFFFF)
            stat_stall_cnt <= stat_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_posit_round_norm_sched.sv
// -----------------------------------------------------------------------------
// tb_posit_round_norm_sched
//
// Directed bench for posit_round_norm_sched with two requesters. The shared
// datapath is stood in by a simple combinational function of rn_exp/rn_mant;
// each requester's exp/mant are derived from its tag so an expected result
// follows from the tag alone. Inputs change 1 ns after the rising edge, and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_posit_round_norm_sched;

   localparam int N_REQ  = 2;
   localparam int EXP_W  = 32;
   localparam int MANT_W = 32;
   localparam int RES_W  = 56;
   localparam int TAG_W  = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*2-1:0]      req_mode;
   logic [N_REQ*EXP_W-1:0]  req_exp;
   logic [N_REQ*MANT_W-1:0] req_mant;
   logic [N_REQ*TAG_W-1:0]  req_tag;
   logic [1:0]              rn_mode;
   logic [EXP_W-1:0]        rn_exp;
   logic [MANT_W-1:0]       rn_mant;
   logic [RES_W-1:0]        rn_res;
   logic                    out_valid;
   logic                    out_ready;
   logic [RES_W-1:0]        out_res;
   logic [1:0]              out_mode;
   logic [TAG_W-1:0]        out_tag;
   logic                    out_src;
   logic                    err_mode;
`ifdef POSIT_RN_SCHED_STATS_EN
   logic [N_REQ*16-1:0]     stat_grant_cnt;
   logic [15:0]             stat_stall_cnt;
`endif

   logic [1:0]       m_q [N_REQ];
   logic [TAG_W-1:0] t_q [N_REQ];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   posit_round_norm_sched #(
      .N_REQ (N_REQ),
      .EXP_W (EXP_W),
      .MANT_W(MANT_W),
      .RES_W (RES_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_mode (req_mode),
      .req_exp  (req_exp),
      .req_mant (req_mant),
      .req_tag  (req_tag),
      .rn_mode  (rn_mode),
      .rn_exp   (rn_exp),
      .rn_mant  (rn_mant),
      .rn_res   (rn_res),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_res  (out_res),
      .out_mode (out_mode),
      .out_tag  (out_tag),
      .out_src  (out_src),
      .err_mode (err_mode)
`ifdef POSIT_RN_SCHED_STATS_EN
      ,
      .stat_grant_cnt(stat_grant_cnt),
      .stat_stall_cnt(stat_stall_cnt)
`endif
   );

   function automatic logic [31:0] exp_of(input logic [3:0] t);
      return {28'hABCDEF0, t};
   endfunction

   function automatic logic [31:0] mant_of(input logic [3:0] t);
      return {t, 28'h1234567};
   endfunction

   function automatic logic [55:0] dp_model(input logic [31:0] e, input logic [31:0] m);
      return {e + 32'h0101_0101, m[31:8] ^ 24'h5A5A5A};
   endfunction

   // Stand-in for the shared round/normalize datapath.
   assign rn_res = dp_model(rn_exp, rn_mant);

   always_comb begin
      req_mode = '0;
      req_tag  = '0;
      req_exp  = '0;
      req_mant = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_mode[i*2 +: 2]          = m_q[i];
         req_tag[i*TAG_W +: TAG_W]   = t_q[i];
         req_exp[i*EXP_W +: EXP_W]   = exp_of(t_q[i]);
         req_mant[i*MANT_W +: MANT_W] = mant_of(t_q[i]);
      end
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", name, obs, exp_v);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [1:0] m, input logic [3:0] t);
      req_valid[i] = v;
      m_q[i]       = m;
      t_q[i]       = t;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input logic [3:0] t, input logic s, input logic [1:0] m);
      check("out_valid", out_valid, 1'b1);
      check("out_tag",   out_tag, t);
      check("out_src",   out_src, s);
      check("out_mode",  out_mode, m);
      check("out_res",   out_res, dp_model(exp_of(t), mant_of(t)));
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      req_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         m_q[i] = '0;
         t_q[i] = '0;
      end
      set_req(0, 1'b1, 2'd0, 4'h1);
      set_req(1, 1'b1, 2'd0, 4'h2);
      next();
      next();

      // Reset state, with requests pending to show ready stays low.
      sample();
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_err_mode",  err_mode, 1'b0);
      check("rst_rn_exp",    rn_exp, 32'h0);
      check("rst_rn_mode",   rn_mode, 2'd0);
      check("rst_out_res",   out_res, 56'h0);
      check("rst_out_tag",   out_tag, 4'h0);
      check("rst_out_src",   out_src, 1'b0);
      next();
      rst = 1'b0;
      req_valid = '0;

      // Single op: grant, one cycle in s1, result two cycles after handshake.
      set_req(0, 1'b1, 2'd0, 4'h3);
      sample();
      check("single_ready", req_ready, 2'b01);
      next();
      set_req(0, 1'b0, 2'd0, 4'h3);
      sample();
      check("single_lat1_valid", out_valid, 1'b0);
      check("single_rn_exp",     rn_exp, exp_of(4'h3));
      check("single_rn_mant",    rn_mant, mant_of(4'h3));
      next();
      sample();
      expect_out(4'h3, 1'b0, 2'd0);
      next();
      sample();
      check("single_after_valid", out_valid, 1'b0);
      next();

      // Round-robin at full throughput, starting from a fresh pointer.
      rst = 1'b1;
      next();
      rst = 1'b0;
      set_req(0, 1'b1, 2'd0, 4'h5);
      set_req(1, 1'b1, 2'd0, 4'h6);
      for (int k = 0; k < 6; k++) begin
         sample();
         check("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k >= 2) expect_out((k % 2 == 0) ? 4'h5 : 4'h6, 1'(k % 2), 2'd0);
         else        check("rr_fill_valid", out_valid, 1'b0);
         next();
      end
      req_valid = '0;
      sample();
      expect_out(4'h5, 1'b0, 2'd0);
      next();
      sample();
      expect_out(4'h6, 1'b1, 2'd0);
      next();
      sample();
      check("rr_drain_valid", out_valid, 1'b0);
      next();

      // Back-pressure: out_ready low for 5 cycles, pointer now at 0.
      out_ready = 1'b0;
      set_req(0, 1'b1, 2'd0, 4'hA);
      set_req(1, 1'b1, 2'd0, 4'hB);
      sample();
      check("bp_ready_c0", req_ready, 2'b01);
      next();
      set_req(0, 1'b1, 2'd0, 4'hC);
      sample();
      check("bp_ready_c1", req_ready, 2'b10);
      next();
      set_req(1, 1'b1, 2'd0, 4'hD);
      for (int k = 2; k < 5; k++) begin
         sample();
         check("bp_ready_stall", req_ready, 2'b00);
         expect_out(4'hA, 1'b0, 2'd0);
         next();
      end
      out_ready = 1'b1;
      sample();
      expect_out(4'hA, 1'b0, 2'd0);
      check("bp_ready_c5", req_ready, 2'b01);
      next();
      set_req(0, 1'b0, 2'd0, 4'hC);
      sample();
      expect_out(4'hB, 1'b1, 2'd0);
      check("bp_ready_c6", req_ready, 2'b10);
      next();
      set_req(1, 1'b0, 2'd0, 4'hD);
      sample();
      expect_out(4'hC, 1'b0, 2'd0);
      next();
      sample();
      expect_out(4'hD, 1'b1, 2'd0);
      next();
      sample();
      check("bp_drain_valid", out_valid, 1'b0);
      next();

      // Reserved mode on requester 1, then a half-precision op from requester 0.
      set_req(1, 1'b1, 2'd3, 4'h9);
      sample();
      check("rsvd_ready", req_ready, 2'b10);
      check("rsvd_err_before", err_mode, 1'b0);
      next();
      set_req(1, 1'b0, 2'd3, 4'h9);
      set_req(0, 1'b1, 2'd1, 4'h7);
      sample();
      check("rsvd_err_set", err_mode, 1'b1);
      check("rsvd_next_ready", req_ready, 2'b01);
      check("rsvd_valid_c1", out_valid, 1'b0);
      next();
      set_req(0, 1'b0, 2'd1, 4'h7);
      sample();
      check("rsvd_dropped", out_valid, 1'b0);
      next();
      sample();
      expect_out(4'h7, 1'b0, 2'd1);
      next();
      sample();
      check("rsvd_after_valid", out_valid, 1'b0);
      check("rsvd_err_sticky", err_mode, 1'b1);
      next();

      // Mid-operation reset with s1 and s2 both full and the pointer at 1.
      out_ready = 1'b0;
      set_req(1, 1'b1, 2'd0, 4'h2);
      sample();
      check("mrst_ready_c0", req_ready, 2'b10);
      next();
      set_req(1, 1'b0, 2'd0, 4'h2);
      set_req(0, 1'b1, 2'd0, 4'h1);
      sample();
      check("mrst_ready_c1", req_ready, 2'b01);
      next();
      set_req(0, 1'b0, 2'd0, 4'h1);
      rst = 1'b1;
      sample();
      expect_out(4'h2, 1'b1, 2'd0);
      next();
      rst = 1'b0;
      sample();
      check("mrst_out_valid", out_valid, 1'b0);
      check("mrst_req_ready", req_ready, 2'b00);
      check("mrst_err_mode",  err_mode, 1'b0);
      check("mrst_rn_exp",    rn_exp, 32'h0);
      next();
      out_ready = 1'b1;
      set_req(0, 1'b1, 2'd2, 4'h4);
      set_req(1, 1'b1, 2'd2, 4'h8);
      sample();
      check("mrst_first_grant", req_ready, 2'b01);
      check("mrst_no_stale",    out_valid, 1'b0);
      next();
      req_valid = '0;
      sample();
      check("mrst_no_stale2", out_valid, 1'b0);
      next();
      sample();
      expect_out(4'h4, 1'b0, 2'd2);
      next();
      sample();
      check("mrst_drain_valid", out_valid, 1'b0);
      next();

`ifdef POSIT_RN_SCHED_STATS_EN
      // Stats: 3 grants to requester 0, 2 to requester 1, 4 stall cycles.
      rst = 1'b1;
      next();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_req(0, 1'b1, 2'd0, 4'(k + 1));
         next();
      end
      set_req(0, 1'b0, 2'd0, 4'h0);
      for (int k = 0; k < 2; k++) begin
         set_req(1, 1'b1, 2'd0, 4'(k + 4));
         next();
      end
      set_req(1, 1'b0, 2'd0, 4'h0);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample();
         check("stat_stall_valid", out_valid, 1'b1);
         next();
      end
      out_ready = 1'b1;
      next();
      next();
      sample();
      check("stat_drain_valid", out_valid, 1'b0);
      check("stat_grant_cnt", stat_grant_cnt, {16'd2, 16'd3});
      check("stat_stall_cnt", stat_stall_cnt, 16'd4);
      next();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/posit_round_norm_sched.md
Name: posit_round_norm_sched

Overview:
- Shares one combinational posit round/normalize/saturate datapath between N_REQ producers (adder, multiplier, ...).
- Arbitrates requests round-robin and registers the winner into a stage-1 register that drives the datapath.
- Captures the datapath result into a stage-2 output register with valid/ready back-pressure.
- Carries precision mode (full / 2x half / 4x quart) and a tag alongside each operation. Sits between the posit arithmetic units and the writeback path.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- EXP_W, 32, packed exponent bundle width. Holds 1 full, 2 half or 4 quart combined exponents.
- MANT_W, 32, packed mantissa bundle width, including the normalize bit per lane.
- RES_W, 56, packed rounded result width (exp + mant, all lanes).
- TAG_W, 4, opaque tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept
- req_mode  in  N_REQ*2  precision per requester: 0 full, 1 half, 2 quart, 3 reserved
- req_exp  in  N_REQ*EXP_W  unrounded exponent bundles
- req_mant  in  N_REQ*MANT_W  unrounded mantissa bundles
- req_tag  in  N_REQ*TAG_W  tags
- rn_mode  out  2  stage-1 mode to datapath
- rn_exp  out  EXP_W  stage-1 exponent to datapath
- rn_mant  out  MANT_W  stage-1 mantissa to datapath
- rn_res  in  RES_W  datapath result (combinational from rn_*)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_res  out  RES_W  registered result
- out_mode  out  2  mode of result
- out_tag  out  TAG_W  tag of result
- out_src  out  $clog2(N_REQ)  index of originating requester
- err_mode  out  1  sticky: reserved mode seen

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset rst is synchronous, active-high.
  - On rst: s1_valid=0, s2_valid=0, out_valid=0, req_ready=0, err_mode=0, rr pointer=0.
  - rn_*, out_res, out_mode, out_tag, out_src = 0.
  - rst mid-operation discards all in-flight operations; nothing is emitted after reset.
- Pipeline:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - Full throughput: one op per cycle when out_ready is held high.
- Arbitration:
  - Round-robin over req_valid, starting at pointer p, combinational in the current cycle.
  - req_ready[i]=1 only for the winner, and only when s1_adv=1. All other req_ready bits are 0.
  - A handshake (req_valid[i] & req_ready[i]) loads s1 from requester i.
  - After a handshake from i, p = (i+1) mod N_REQ. Otherwise p holds.
  - Requesters must hold their payload stable while valid and not ready; the block does not check this.
- Stage 1:
  - rn_mode, rn_exp and rn_mant are driven directly from the s1 registers.
  - They hold their value while s1 is stalled.
- Stage 2:
  - When s1_valid & s2_adv, s2 captures rn_res, mode, tag and src, and s2_valid=1.
  - When s2_adv & !s1_valid, s2_valid=0.
- Latency: a handshake at cycle t gives out_valid at t+2 with no back-pressure.
- Back-pressure:
  - With out_ready=0, s2 holds its contents.
  - s1 fills once, then all req_ready=0.
  - Nothing is lost or duplicated.
- Reserved mode 3:
  - The op is accepted normally and sets err_mode=1. err_mode is sticky until rst.
  - The op is dropped at the s1→s2 transfer: it does not set s2_valid and is not emitted.
- Simultaneous events: if out_ready=1, s1 holds an op and a new grant occurs in the same cycle, all three transfers happen.
- No reordering: results leave in grant order.

Optional Feature:
- Macro: POSIT_RN_SCHED_STATS_EN.
- When defined, the block adds:
  - Output stat_grant_cnt (N_REQ*16): per-requester handshake counters.
  - Output stat_stall_cnt (16): counts cycles with out_valid & !out_ready.
- Counter behaviour: all counters saturate at 16'hFFFF and are cleared by rst.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Single op:
  - Stimulus: rst, then req_valid[0]=1, mode=0, tag=4'h3.
  - Response: req_ready[0]=1 at t0; out_valid at t0+2 with out_tag=3, out_src=0, out_res equal to the datapath result for that input.
- Round-robin:
  - Stimulus: both requesters valid continuously, out_ready=1.
  - Response: grants alternate 0,1,0,1; out_src alternates; one out_valid per cycle from t0+2.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles with both requesters valid.
  - Response: exactly 2 ops accepted, req_ready=0 afterwards, out_res/out_tag stable.
  - Then out_ready=1: results drain in grant order with none lost.
- Reserved mode:
  - Stimulus: req_mode=3 on requester 1, tag=4'h9.
  - Response: handshake occurs; err_mode=1 from the next cycle; no out_valid carries tag 9; following ops emit normally.
- Mid-operation reset:
  - Stimulus: assert rst with s1 and s2 both valid.
  - Response: next cycle out_valid=0, req_ready=0, err_mode=0; the first grant after reset goes to requester 0.
- Stats (POSIT_RN_SCHED_STATS_EN):
  - Stimulus: 3 grants to requester 0, 2 to requester 1, 4 stall cycles.
  - Response: stat_grant_cnt = {2,3}, stat_stall_cnt = 4.
